// File: rtl/bus_register_8b_if.sv
// Bus-side signal bundle for the 8-bit bus register: capture data, command strobes,
// tri-state drive and status outputs.
interface bus_register_8b_if;
    logic [7:0] input_a;
    logic       input_load;
    logic       input_load_inv;
    logic       input_clr;
    logic       input_inc;
    logic       input_dec;
    logic       input_enable;
    wire  [7:0] output_z;
    logic [7:0] output_q;
    logic       output_zero;
    logic       output_carry;

    modport master (
        output input_a, input_load, input_load_inv, input_clr,
        output input_inc, input_dec, input_enable,
        input  output_z, output_q, output_zero, output_carry
    );

    modport slave (
        input  input_a, input_load, input_load_inv, input_clr,
        input  input_inc, input_dec, input_enable,
        output output_z, output_q, output_zero, output_carry
    );
endinterface

// File: rtl/bus_register_8b.sv
// 8-bit general-purpose/accumulator register: captures the bus (optionally complemented),
// supports clear/inc/dec with a wrap flag, and drives its value back onto the bus.
module bus_register_8b (
    input  logic              input_clk,
    input  logic              input_reset,
    bus_register_8b_if.slave  bus
);
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_LOAD_INV,
        OP_INC,
        OP_DEC
    } op_e;

    op_e        op;
    logic [7:0] q_d, q_q;
    logic       carry_d, carry_q;

    // One action per edge; lower-priority strobes in the same cycle are dropped.
    always_comb begin
        op = OP_HOLD;
        if (bus.input_clr)           op = OP_CLR;
        else if (bus.input_load)     op = OP_LOAD;
        else if (bus.input_load_inv) op = OP_LOAD_INV;
        else if (bus.input_inc)      op = OP_INC;
        else if (bus.input_dec)      op = OP_DEC;
    end

    always_comb begin
        q_d     = q_q;
        carry_d = carry_q;
        case (op)
            OP_CLR: begin
                q_d     = 8'h00;
                carry_d = 1'b0;
            end
            OP_LOAD: begin
                q_d     = bus.input_a;
                carry_d = 1'b0;
            end
            OP_LOAD_INV: begin
                q_d     = ~bus.input_a;
                carry_d = 1'b0;
            end
            OP_INC: begin
                q_d     = q_q + 8'd1;
                carry_d = (q_q == 8'hFF);
            end
            OP_DEC: begin
                q_d     = q_q - 8'd1;
                carry_d = (q_q == 8'h00);
            end
            default: ;
        endcase
    end

    always_ff @(posedge input_clk) begin
        if (input_reset) begin
            q_q     <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            carry_q <= carry_d;
        end
    end

    // Enable is deliberately not gated by reset; the bus sees q as-is.
    assign bus.output_z     = bus.input_enable ? q_q : 8'hzz;
    assign bus.output_q     = q_q;
    assign bus.output_zero  = (q_q == 8'h00);
    assign bus.output_carry = carry_q;
endmodule

// File: tb/tb_bus_register_8b.sv
// Self-checking bench for bus_register_8b: directed test points plus random commands,
// compared every cycle against a behavioural model of the register.
module tb_bus_register_8b;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    bus_register_8b_if bus ();

    bus_register_8b dut (
        .input_clk   (clk),
        .input_reset (rst),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: register value and wrap flag as plain integers.
    int mq = 0;
    int mc = 0;
    bit known = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq = 0; mc = 0; known = 1'b1;
        end else if (known) begin
            if (bus.input_clr) begin
                mq = 0; mc = 0;
            end else if (bus.input_load) begin
                mq = int'(bus.input_a); mc = 0;
            end else if (bus.input_load_inv) begin
                mq = 255 - int'(bus.input_a); mc = 0;
            end else if (bus.input_inc) begin
                mc = (mq == 255) ? 1 : 0;
                mq = (mq + 1) % 256;
            end else if (bus.input_dec) begin
                mc = (mq == 0) ? 1 : 0;
                mq = (mq + 255) % 256;
            end
        end
    end

    // Compare process, away from the active edge.
    always @(negedge clk) begin
        if (known) begin
            checks++;
            if (int'(bus.output_q) != mq) begin
                errors++;
                $display("FAIL model_q: got %02h expected %02h at %0t", bus.output_q, mq[7:0], $time);
            end
            checks++;
            if (bus.output_zero !== (mq == 0)) begin
                errors++;
                $display("FAIL model_zero: got %0b expected %0b at %0t", bus.output_zero, (mq == 0), $time);
            end
            checks++;
            if (int'(bus.output_carry) != mc) begin
                errors++;
                $display("FAIL model_carry: got %0b expected %0d at %0t", bus.output_carry, mc, $time);
            end
            if (bus.input_enable) begin
                checks++;
                if (int'(bus.output_z) != mq) begin
                    errors++;
                    $display("FAIL model_z: got %02h expected %02h at %0t", bus.output_z, mq[7:0], $time);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.input_load = 0; bus.input_load_inv = 0; bus.input_clr = 0;
        bus.input_inc = 0; bus.input_dec = 0; rst = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] x;

    initial begin
        bus.input_a = 8'h00; bus.input_enable = 0;
        idle();
        rst = 1;
        cyc();
        idle();
        chk("reset_q", bus.output_q, 8'h00);
        chk("reset_zero", {7'd0, bus.output_zero}, 8'h01);
        chk("reset_carry", {7'd0, bus.output_carry}, 8'h00);

        // Load A5, then observe on the bus
        bus.input_load = 1; bus.input_a = 8'hA5;
        cyc();
        idle();
        chk("load_q", bus.output_q, 8'hA5);
        chk("load_zero", {7'd0, bus.output_zero}, 8'h00);
        chk("load_carry", {7'd0, bus.output_carry}, 8'h00);
        bus.input_enable = 1;
        #1;
        chk("load_z_en", bus.output_z, 8'hA5);
        bus.input_enable = 0;

        // Inverter restore: original x sent through inverter arrives as ~x
        for (int e = 0; e < 2; e++) begin
            for (int d = 0; d < 2; d++) begin
                x = (d == 0) ? 8'h00 : 8'hFF;
                bus.input_enable = e[0];
                bus.input_a = ~x;
                bus.input_load_inv = 1;
                cyc();
                idle();
                chk("load_inv_q", bus.output_q, x);
                chk("load_inv_zero", {7'd0, bus.output_zero}, {7'd0, x == 8'h00});
                if (e == 1) chk("load_inv_z", bus.output_z, x);
            end
        end
        bus.input_enable = 0;

        // Increment across wrap
        bus.input_load = 1; bus.input_a = 8'hFE;
        cyc();
        idle();
        bus.input_inc = 1;
        cyc();
        chk("inc1_q", bus.output_q, 8'hFF);
        chk("inc1_c", {7'd0, bus.output_carry}, 8'h00);
        cyc();
        chk("inc2_q", bus.output_q, 8'h00);
        chk("inc2_c", {7'd0, bus.output_carry}, 8'h01);
        chk("inc2_zero", {7'd0, bus.output_zero}, 8'h01);
        cyc();
        idle();
        chk("inc3_q", bus.output_q, 8'h01);
        chk("inc3_c", {7'd0, bus.output_carry}, 8'h00);
        chk("inc3_zero", {7'd0, bus.output_zero}, 8'h00);

        // Clear then decrement across wrap
        bus.input_clr = 1;
        cyc();
        idle();
        chk("clr_q", bus.output_q, 8'h00);
        bus.input_dec = 1;
        cyc();
        chk("dec1_q", bus.output_q, 8'hFF);
        chk("dec1_c", {7'd0, bus.output_carry}, 8'h01);
        cyc();
        idle();
        chk("dec2_q", bus.output_q, 8'hFE);
        chk("dec2_c", {7'd0, bus.output_carry}, 8'h00);

        // Priority
        bus.input_a = 8'h3C;
        bus.input_load = 1; bus.input_inc = 1; bus.input_dec = 1; bus.input_load_inv = 1;
        cyc();
        chk("prio_load", bus.output_q, 8'h3C);
        bus.input_clr = 1;
        cyc();
        idle();
        chk("prio_clr", bus.output_q, 8'h00);

        // Reset wins over inc, with bus drive enabled
        bus.input_load = 1; bus.input_a = 8'h77;
        cyc();
        idle();
        bus.input_enable = 1;
        #1;
        chk("pre_rst_z", bus.output_z, 8'h77);
        rst = 1; bus.input_inc = 1;
        cyc();
        idle();
        chk("rst_inc_q", bus.output_q, 8'h00);
        chk("rst_inc_z", bus.output_z, 8'h00);
        chk("rst_inc_c", {7'd0, bus.output_carry}, 8'h00);

        // Random commands
        for (int i = 0; i < 2000; i++) begin
            bus.input_a        = 8'($urandom);
            bus.input_clr      = ($urandom_range(0, 15) == 0);
            bus.input_load     = ($urandom_range(0, 7) == 0);
            bus.input_load_inv = ($urandom_range(0, 7) == 0);
            bus.input_inc      = ($urandom_range(0, 2) == 0);
            bus.input_dec      = ($urandom_range(0, 2) == 0);
            bus.input_enable   = $urandom_range(0, 1) == 1;
            rst                = ($urandom_range(0, 63) == 0);
            cyc();
        end
        idle();
        cyc();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
